// File: rtl/vga_fb_reader_if.sv
// Frame-buffer scan-out bus: RAM read port plus colour/sync stream to the DAC.
// The reader drives the master modport; RAM model and DAC side use slave.
interface vga_fb_reader_if #(
  parameter int ADDR_W  = 19,
  parameter int COLOR_W = 8
);
  logic [ADDR_W-1:0]  oaddr;
  logic               ordren;
  logic [COLOR_W-1:0] iram_data;
  logic [COLOR_W-1:0] ocolor;
  logic               ocolor_vld;
  logic               ohsync;
  logic               ovsync;
  logic               oframe_start;

  modport master (
    output oaddr, ordren, ocolor, ocolor_vld, ohsync, ovsync, oframe_start,
    input  iram_data
  );

  modport slave (
    input  oaddr, ordren, ocolor, ocolor_vld, ohsync, ovsync, oframe_start,
    output iram_data
  );
endinterface

// File: rtl/vga_fb_reader.sv
// VGA frame-buffer scan-out: raster counters, one RAM read per visible pixel,
// and a sync/blank delay line matched to the RAM read latency so colour and
// syncs leave the block together.
module vga_fb_reader #(
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int H_CNT_WIDTH    = 10,
  parameter int V_CNT_WIDTH    = 10,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8,
  parameter int RD_LATENCY     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  vga_fb_reader_if.master    fb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_CNT_WIDTH-1:0] H_LAST     = H_CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [H_CNT_WIDTH-1:0] H_ACT_END  = H_CNT_WIDTH'(H_ACTIVE);
  localparam logic [H_CNT_WIDTH-1:0] H_SYNC_BEG = H_CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_WIDTH-1:0] H_SYNC_END = H_CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [V_CNT_WIDTH-1:0] V_LAST     = V_CNT_WIDTH'(V_TOTAL - 1);
  localparam logic [V_CNT_WIDTH-1:0] V_ACT_END  = V_CNT_WIDTH'(V_ACTIVE);
  localparam logic [V_CNT_WIDTH-1:0] V_SYNC_BEG = V_CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_WIDTH-1:0] V_SYNC_END = V_CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);

  // One raster position's worth of video qualifiers; syncs are active low.
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } stage_t;

  // Idle value: blanked, both syncs deasserted, no frame-start.
  localparam stage_t IDLE = stage_t'(4'b0110);

  logic [H_CNT_WIDTH-1:0]    hCnt_q, hCnt_d;
  logic [V_CNT_WIDTH-1:0]    vCnt_q, vCnt_d;
  logic [VGA_ADDR_WIDTH-1:0] addrCnt_q, addrCnt_d;
  logic [VGA_ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
  stage_t                    st0_q, st0_d;
  stage_t                    pipe_q [RD_LATENCY];
  stage_t                    pipeOut;
  logic                      hLast;
  logic                      vLast;
  logic [COLOR_ID_WIDTH-1:0] colorOut;

  // Next raster position, stage-0 qualifiers and the running read address.
  // The address counter reloads on the frame wrap so it never walks past
  // the last visible pixel into the next frame.
  always_comb begin
    hLast     = (hCnt_q == H_LAST);
    vLast     = (vCnt_q == V_LAST);
    hCnt_d    = hLast ? '0 : hCnt_q + 1'b1;
    vCnt_d    = vCnt_q;
    if (hLast) begin
      vCnt_d = vLast ? '0 : vCnt_q + 1'b1;
    end
    st0_d.act = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
    st0_d.hs  = !((hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END));
    st0_d.vs  = !((vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END));
    st0_d.fs  = (hCnt_q == '0) && (vCnt_q == '0);
    oaddr_d   = st0_d.act ? addrCnt_q : '0;
    addrCnt_d = addrCnt_q;
    if (hLast && vLast) begin
      addrCnt_d = '0;
    end else if (st0_d.act) begin
      addrCnt_d = addrCnt_q + 1'b1;
    end
  end

  // Raster counters and registered read request; en low parks everything
  // at (0,0) so the next enabled clock restarts the frame from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      addrCnt_q <= '0;
      oaddr_q   <= '0;
      st0_q     <= IDLE;
    end else if (!en) begin
      hCnt_q    <= '0;
      vCnt_q    <= '0;
      addrCnt_q <= '0;
      oaddr_q   <= '0;
      st0_q     <= IDLE;
    end else begin
      hCnt_q    <= hCnt_d;
      vCnt_q    <= vCnt_d;
      addrCnt_q <= addrCnt_d;
      oaddr_q   <= oaddr_d;
      st0_q     <= st0_d;
    end
  end

  // Delay line matching the RAM read latency so blank/sync/frame-start line
  // up with the data returned for the same pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= IDLE;
      end
    end else if (!en) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_q[i] <= IDLE;
      end
    end else begin
      pipe_q[0] <= st0_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign pipeOut  = pipe_q[RD_LATENCY-1];
  assign colorOut = pipeOut.act ? fb.iram_data : '0;

  assign fb.oaddr        = oaddr_q;
  assign fb.ordren       = st0_q.act;
  assign fb.ocolor       = colorOut;
  assign fb.ocolor_vld   = pipeOut.act;
  assign fb.ohsync       = pipeOut.hs;
  assign fb.ovsync       = pipeOut.vs;
  assign fb.oframe_start = pipeOut.fs;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader on a shrunken raster (8x6 visible, 15x11 total)
// so several whole frames, a mid-frame reset and an enable drop fit in a
// short run. The RAM model returns addr[7:0]^0x5A after RD_LATENCY clocks.
module tb_vga_fb_reader;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX = HA * VA;
  localparam int LAT = 2;
  localparam int AW = 19;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  logic en;

  vga_fb_reader_if #(.ADDR_W(AW), .COLOR_W(CW)) fb ();

  vga_fb_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_CNT_WIDTH(10), .V_CNT_WIDTH(10),
    .VGA_ADDR_WIDTH(AW), .COLOR_ID_WIDTH(CW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .fb(fb)
  );

  always #5 clk = ~clk;

  // RAM model: fixed-latency read returning a scrambled low address byte.
  logic [CW-1:0] ramPipe [LAT];
  always @(posedge clk) begin
    ramPipe[0] <= fb.oaddr[7:0] ^ 8'h5A;
    for (int i = 1; i < LAT; i++) ramPipe[i] <= ramPipe[i-1];
  end
  assign fb.iram_data = ramPipe[LAT-1];

  int            total = 0;
  int            bad = 0;
  int            addrQ[$];
  logic [CW-1:0] pixQ[$];
  int            lastAddr = -1;
  bit            tracking = 0;
  int            pos = 0;

  task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e);
    @(negedge clk);
    rst = r;
    en = e;
  endtask

  task automatic pushFrame();
    for (int a = 0; a < NPIX; a++) begin
      addrQ.push_back(a);
      pixQ.push_back(8'(a) ^ 8'h5A);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ordren"}, fb.ordren, 0);
    checkOutput({tag, "_oaddr"}, fb.oaddr, 0);
    checkOutput({tag, "_ocolor"}, fb.ocolor, 0);
    checkOutput({tag, "_vld"}, fb.ocolor_vld, 0);
    checkOutput({tag, "_hsync"}, fb.ohsync, 1);
    checkOutput({tag, "_vsync"}, fb.ovsync, 1);
    checkOutput({tag, "_fs"}, fb.oframe_start, 0);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    while (pixQ.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_pix_left"}, pixQ.size(), 0);
    checkOutput({tag, "_addr_left"}, addrQ.size(), 0);
  endtask

  task automatic waitAddr(input string tag, input int target, input int budget);
    int n = 0;
    while (lastAddr != target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({tag, "_reached"}, lastAddr, target);
  endtask

  // Monitor: pops the scoreboard on every read request and every valid
  // pixel, and checks sync/blank against a raster model anchored at the
  // first observed frame start.
  always @(negedge clk) begin
    int h, v;
    if (rst) begin
      tracking = 0;
    end else begin
      if (fb.ordren) begin
        if (addrQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL addr_unexpected: got %0d required none", fb.oaddr);
        end else begin
          int ea;
          ea = addrQ.pop_front();
          checkOutput("oaddr", fb.oaddr, ea);
          lastAddr = ea;
        end
      end else begin
        checkOutput("oaddr_blank", fb.oaddr, 0);
      end
      if (fb.ocolor_vld) begin
        if (pixQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL pix_unexpected: got %0d required none", fb.ocolor);
        end else begin
          checkOutput("ocolor", fb.ocolor, pixQ.pop_front());
        end
      end else begin
        checkOutput("ocolor_blank", fb.ocolor, 0);
      end
      if (fb.oframe_start && !tracking) begin
        tracking = 1;
        pos = 0;
      end
      if (tracking) begin
        h = pos % HT;
        v = pos / HT;
        checkOutput("t_vld", fb.ocolor_vld, (h < HA && v < VA) ? 1 : 0);
        checkOutput("t_hsync", fb.ohsync, (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1);
        checkOutput("t_vsync", fb.ovsync, (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1);
        checkOutput("t_fs", fb.oframe_start, (pos == 0) ? 1 : 0);
        pos = (pos + 1) % FRAME;
      end
    end
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkIdle("reset");

    // Two full frames from reset release, crossing the frame wrap.
    pushFrame();
    pushFrame();
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1 checkOutput("first_ordren", fb.ordren, 1);
    checkOutput("first_oaddr", fb.oaddr, 0);
    @(posedge clk);
    #1 checkOutput("fs_early", fb.oframe_start, 0);
    @(posedge clk);
    #1 checkOutput("fs_first", fb.oframe_start, 1);
    checkOutput("vld_first", fb.ocolor_vld, 1);
    checkOutput("color_first", fb.ocolor, 8'h5A);
    waitDrain("run1", 2 * FRAME + 50);

    // Asynchronous reset in the middle of line 2.
    pushFrame();
    waitAddr("mid2", 2 * HA + 3, FRAME + 50);
    @(posedge clk);
    #2 rst = 1'b1;
    addrQ.delete();
    pixQ.delete();
    #1 checkIdle("async_rst");
    repeat (3) @(posedge clk);
    pushFrame();
    applyStimulus(1'b0, 1'b1);
    waitDrain("run2", FRAME + 50);

    // Enable dropped in line 5 for ten clocks.
    pushFrame();
    waitAddr("line5", 5 * HA + 2, FRAME + 50);
    applyStimulus(1'b0, 1'b0);
    @(posedge clk);
    #1 addrQ.delete();
    pixQ.delete();
    tracking = 0;
    checkIdle("en_off");
    repeat (9) @(posedge clk);
    #1 checkIdle("en_off_hold");
    pushFrame();
    applyStimulus(1'b0, 1'b1);
    @(posedge clk);
    #1 checkOutput("reen_ordren", fb.ordren, 1);
    checkOutput("reen_oaddr", fb.oaddr, 0);
    @(posedge clk);
    @(posedge clk);
    #1 checkOutput("reen_fs", fb.oframe_start, 1);
    waitDrain("run3", FRAME + 50);

    applyStimulus(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkIdle("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
